// File: rtl/fmul_e4m3_arbiter.sv
// ---------------------------------------------------------------------------
// fmul_e4m3_arbiter
//
// Purpose:
//   Shares a single external e4m3 multiplier between four requesters. A
//   round-robin arbiter grants one request at a time. The operands are
//   registered and the multiplier is restarted for one cycle. The FSM then
//   waits a bounded number of cycles for the multiplier's valid flag. The
//   result, or a timeout error, is presented on a valid/ready response port.
//
// Ports:
//   clock      in   1   single clock, rising edge
//   reset      in   1   synchronous, active-low reset
//   req_valid  in   4   per-requester request, bit i = requester i
//   req_a      in  32   operand A, requester i on bits [8i+7:8i]
//   req_b      in  32   operand B, same packing as req_a
//   req_ready  out  4   one-hot grant (only in IDLE)
//   rsp_valid  out  1   result available (RESP state)
//   rsp_ready  in   1   consumer accepts the result
//   rsp_id     out  2   requester owning the result
//   rsp_y      out  8   e4m3 product (0 when rsp_err)
//   rsp_err    out  1   operation aborted by timeout
//   busy       out  1   high in every state except IDLE
//   mul_a      out  8   operand A to the shared multiplier
//   mul_b      out  8   operand B to the shared multiplier
//   mul_reset  out  1   active-high multiplier restart, low only in WAIT
//   mul_y      in   8   multiplier result
//   mul_valid  in   1   multiplier result valid (used only in WAIT)
// ---------------------------------------------------------------------------
module fmul_e4m3_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [3:0]  req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_id,
  output logic [7:0]  rsp_y,
  output logic        rsp_err,
  output logic        busy,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  output logic        mul_reset,
  input  logic [7:0]  mul_y,
  input  logic        mul_valid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Last counter value before the wait is abandoned.
  localparam logic [3:0] LP_LAST = 4'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_nextState;
  logic [1:0]  r_ptr;
  logic [3:0]  r_cnt;
  logic [7:0]  r_mulA;
  logic [7:0]  r_mulB;
  logic [7:0]  r_rspY;
  logic [1:0]  r_rspId;
  logic        r_rspErr;
  logic [1:0]  w_grantIdx;
  logic        w_anyReq;
  logic        w_grant;

  // Round-robin pick: scan upward from r_ptr with wrap 3->0 and take the
  // first active request.
  always_comb begin : rrPick
    logic [1:0] idx;
    w_grantIdx = r_ptr;
    w_anyReq   = 1'b0;
    idx        = r_ptr;
    for (int k = 0; k < 4; k++) begin
      idx = r_ptr + 2'(k);
      if (!w_anyReq && req_valid[idx]) begin
        w_anyReq   = 1'b1;
        w_grantIdx = idx;
      end
    end
  end

  // A grant only exists in IDLE and never while reset is held. Reset wins
  // over the handshake.
  assign w_grant = reset && (r_state == S_IDLE) && w_anyReq;

  // Next-state decode. The handshakes themselves are qualified by reset in
  // the state register process.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (w_anyReq) w_nextState = S_START;
      S_START: w_nextState = S_WAIT;
      S_WAIT:  if (mul_valid || (r_cnt == LP_LAST)) w_nextState = S_RESP;
      S_RESP:  if (rsp_ready) w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Output decode. Each output is qualified by reset, so the block shows
  // its idle face while reset is low, even before the state register
  // has cleared.
  always_comb begin
    req_ready = 4'b0000;
    if (w_grant) req_ready = 4'b0001 << w_grantIdx;
    busy      = reset && (r_state != S_IDLE);
    rsp_valid = reset && (r_state == S_RESP);
    mul_reset = !reset || (r_state != S_WAIT);
  end

  // State and datapath registers. The operands are captured only on the
  // IDLE grant, so they stay stable for the whole operation. In WAIT, a
  // valid result takes priority over the timeout on the last cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_ptr    <= 2'd0;
      r_cnt    <= 4'd0;
      r_mulA   <= 8'd0;
      r_mulB   <= 8'd0;
      r_rspY   <= 8'd0;
      r_rspId  <= 2'd0;
      r_rspErr <= 1'b0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        S_IDLE: begin
          if (w_anyReq) begin
            r_mulA  <= req_a[{w_grantIdx, 3'b000} +: 8];
            r_mulB  <= req_b[{w_grantIdx, 3'b000} +: 8];
            r_rspId <= w_grantIdx;
          end
        end
        S_START: r_cnt <= 4'd0;
        S_WAIT: begin
          if (mul_valid) begin
            r_rspY   <= mul_y;
            r_rspErr <= 1'b0;
          end else if (r_cnt == LP_LAST) begin
            r_rspY   <= 8'd0;
            r_rspErr <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_RESP: if (rsp_ready) r_ptr <= r_rspId + 2'd1;
        default: ;
      endcase
    end
  end

  assign mul_a   = r_mulA;
  assign mul_b   = r_mulB;
  assign rsp_y   = r_rspY;
  assign rsp_id  = r_rspId;
  assign rsp_err = r_rspErr;

endmodule

// File: doc/fmul_e4m3_arbiter.md
FMUL_E4M3_ARBITER -- requirements
Module: fmul_e4m3_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, maximum multiplier-wait cycles before abort (range 2..15).
REQ-002 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock only.
REQ-004 SHALL have port req_valid  input  4  per-requester operation request, bit i = requester i.
REQ-005 SHALL have port req_a  input  32  e4m3 operand A, requester i on bits [8i+7:8i].
REQ-006 SHALL have port req_b  input  32  e4m3 operand B, same packing as req_a.
REQ-007 SHALL have port req_ready  output  4  one-hot grant; a request is accepted when req_valid[i] and req_ready[i] are both 1.
REQ-008 SHALL have port rsp_valid  output  1  result available.
REQ-009 SHALL have port rsp_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port rsp_id  output  2  index of the requester that owns the result.
REQ-011 SHALL have port rsp_y  output  8  e4m3 product.
REQ-012 SHALL have port rsp_err  output  1  result aborted by timeout; rsp_y is 0 when set.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have ports mul_a, mul_b  output  8 each  operands driven to the shared e4m3 multiplier.
REQ-015 SHALL have port mul_reset  output  1  active-high restart of the multiplier.
REQ-016 SHALL have ports mul_y  input  8, mul_valid  input  1  multiplier result and its valid flag.

Function
REQ-017 SHALL implement a four-state FSM: IDLE, START, WAIT, RESP.
REQ-018 IDLE: when any req_valid bit is set, SHALL assert req_ready for exactly one requester, chosen round-robin by scanning upward from ptr with wrap 3->0; otherwise req_ready=0.
REQ-019 On an IDLE handshake, SHALL register the operands into mul_a/mul_b and the index into rsp_id, then move to START; req_ready SHALL be 0 in all other states.
REQ-020 START SHALL last exactly one cycle with mul_reset=1, then move to WAIT with the wait counter cleared.
REQ-021 mul_reset SHALL be 1 in IDLE, START and RESP, and 0 only in WAIT; it SHALL be decoded from the state register.
REQ-022 mul_a/mul_b SHALL hold constant from START until the next IDLE handshake.
REQ-023 WAIT: mul_valid=1 SHALL capture mul_y into rsp_y, set rsp_err=0 and move to RESP.
REQ-024 WAIT: while mul_valid=0 the 4-bit counter SHALL increment by 1 each cycle; if mul_valid=0 while the counter equals TIMEOUT-1, the FSM SHALL set rsp_y=0 and rsp_err=1 and move to RESP. WAIT SHALL therefore never exceed TIMEOUT cycles.
REQ-025 If mul_valid=1 in the same cycle the counter reaches TIMEOUT-1, the valid result SHALL win and rsp_err SHALL be 0.
REQ-026 RESP: rsp_valid SHALL be 1, with rsp_y, rsp_id and rsp_err stable, until a cycle with rsp_ready=1; rsp_valid SHALL be 0 in all other states.
REQ-027 On the RESP handshake, SHALL set ptr = rsp_id+1 (mod 4) and return to IDLE; no new request SHALL be accepted in that same cycle.
REQ-028 mul_valid SHALL be ignored outside WAIT.
REQ-029 Latency: request accepted at cycle T; START at T+1; earliest rsp_valid at T+3, i.e. one cycle after mul_valid is sampled in WAIT.
REQ-030 Throughput: one operation in flight at most; req_valid changes outside IDLE SHALL have no effect.

Reset
REQ-031 With reset=0 at a rising edge, SHALL force state=IDLE, ptr=0, counter=0, mul_a=mul_b=0, rsp_y=0, rsp_id=0, rsp_err=0.
REQ-032 During and after reset, outputs SHALL read rsp_valid=0, req_ready=0, busy=0, mul_reset=1.
REQ-033 Reset asserted mid-operation (START, WAIT or RESP) SHALL discard the operation with no response.
REQ-034 Reset SHALL take priority over every handshake in the same cycle.

Verification
REQ-035 Single operation: requester 2 sends a=0x38, b=0x38 with the real multiplier attached -> rsp_valid=1, rsp_id=2, rsp_y=0x38, rsp_err=0.
REQ-036 Fairness: all four req_valid held high, rsp_ready=1, ptr=0 -> grant order 0,1,2,3,0, each grant one-hot.
REQ-037 Timeout: stub holds mul_valid=0 with TIMEOUT=15 -> exactly 15 WAIT cycles, then rsp_valid=1, rsp_err=1, rsp_y=0x00.
REQ-038 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_y and rsp_id stable; req_ready=0 throughout.
REQ-039 Zero operand: a=0x80, b=0x45 -> rsp_y sign bit 1 with exponent/mantissa 0 (rsp_y=0x80), rsp_err=0.
REQ-040 Reset mid-WAIT: reset=0 for 1 cycle -> next cycle IDLE, rsp_valid=0, ptr=0, mul_reset=1, and no stale response afterward.
